// File: rtl/sys_rst_seq.sv
// sys_rst_seq: staged reset sequencer.
// Takes the board async active-low reset and produces NUM_STAGES resets that
// deassert synchronously, one after another, once the clock source reports lock.
// A lock timeout ends in a sticky FAULT state. All outputs come from flops.
module sys_rst_seq #(
  parameter int NUM_STAGES   = 4,
  parameter int SYNC_STAGES  = 2,
  parameter int HOLD_CYCLES  = 16,
  parameter int STAGE_GAP    = 8,
  parameter int LOCK_TIMEOUT = 1024,
  parameter int CNT_W        = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  lock_i,
  input  logic                  soft_rst_req,
  output logic [NUM_STAGES-1:0] rst_out_n,
  output logic                  rst_done,
  output logic                  lock_timeout,
  output logic [2:0]            state_o
);

  localparam int IDX_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

  typedef enum logic [2:0] {
    HOLD      = 3'd0,
    WAIT_LOCK = 3'd1,
    RELEASE   = 3'd2,
    RUN       = 3'd3,
    FAULT     = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [SYNC_STAGES-1:0] rst_sync_q;
  logic [1:0]            lock_sync_q;
  logic                  rst_sync, lock_s;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [NUM_STAGES-1:0] out_q, out_d;
  logic                  done_q, done_d;
  logic                  to_q, to_d;

  logic hold_term, gap_term, to_term, last_idx;

  assign rst_sync  = rst_sync_q[SYNC_STAGES-1];
  assign lock_s    = lock_sync_q[1];
  assign hold_term = (cnt_q == CNT_W'(HOLD_CYCLES - 1));
  assign gap_term  = (cnt_q == CNT_W'(STAGE_GAP - 1));
  assign to_term   = (cnt_q == CNT_W'(LOCK_TIMEOUT - 1));
  assign last_idx  = (idx_q == IDX_W'(NUM_STAGES - 1));

  // Reset-deassert synchronizer: async clear, shifts in ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync_q <= '0;
    else        rst_sync_q <= {rst_sync_q[SYNC_STAGES-2:0], 1'b1};
  end

  // Two-flop synchronizer for the asynchronous lock indication
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lock_sync_q <= '0;
    else        lock_sync_q <= {lock_sync_q[0], lock_i};
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= HOLD;
    else        state_q <= state_d;
  end

  // Next-state logic: soft reset first, then lock loss, then progression
  always_comb begin
    state_d = state_q;
    if (soft_rst_req) begin
      state_d = HOLD;
    end else if (rst_sync) begin
      case (state_q)
        HOLD:      if (hold_term) state_d = WAIT_LOCK;
        WAIT_LOCK: begin
          if (lock_s)       state_d = RELEASE;
          else if (to_term) state_d = FAULT;
        end
        RELEASE: begin
          if (!lock_s)                  state_d = HOLD;
          else if (gap_term && last_idx) state_d = RUN;
        end
        RUN:       if (!lock_s) state_d = HOLD;
        FAULT:     state_d = FAULT;
        default:   state_d = HOLD;
      endcase
    end
  end

  // Next values of counter, stage index and registered outputs
  always_comb begin
    cnt_d  = cnt_q;
    idx_d  = idx_q;
    out_d  = out_q;
    done_d = done_q;
    to_d   = to_q;
    if (soft_rst_req) begin
      cnt_d  = '0;
      idx_d  = '0;
      out_d  = '0;
      done_d = 1'b0;
      to_d   = 1'b0;
    end else if (rst_sync) begin
      case (state_q)
        HOLD: begin
          if (hold_term) cnt_d = '0;
          else           cnt_d = cnt_q + 1'b1;
        end
        WAIT_LOCK: begin
          if (lock_s) begin
            cnt_d = '0;
            idx_d = '0;
          end else if (to_term) begin
            cnt_d = '0;
            to_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        RELEASE: begin
          if (!lock_s) begin
            cnt_d  = '0;
            idx_d  = '0;
            out_d  = '0;
            done_d = 1'b0;
          end else if (gap_term) begin
            cnt_d        = '0;
            out_d[idx_q] = 1'b1;
            if (last_idx) done_d = 1'b1;
            else          idx_d  = idx_q + 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        RUN: begin
          if (!lock_s) begin
            cnt_d  = '0;
            idx_d  = '0;
            out_d  = '0;
            done_d = 1'b0;
          end
        end
        FAULT: begin
          out_d = '0;
          to_d  = 1'b1;
        end
        default: begin
          cnt_d = '0;
          idx_d = '0;
          out_d = '0;
        end
      endcase
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      idx_q  <= '0;
      out_q  <= '0;
      done_q <= 1'b0;
      to_q   <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      out_q  <= out_d;
      done_q <= done_d;
      to_q   <= to_d;
    end
  end

  assign rst_out_n    = out_q;
  assign rst_done     = done_q;
  assign lock_timeout = to_q;
  assign state_o      = state_q;

endmodule
